// File: rtl/aurora_pkg.sv
// Definitions shared by the Aurora frame generator and checker.
// Covers the payload LFSR, the checker states and the error-flag bit positions.
package aurora_pkg;

  localparam int HDR_W = 16;

  // Fibonacci x^16+x^15+x^13+x^4+1: feedback taps at bits 15, 14, 12, 3
  localparam logic [15:0] LFSR_TAPS = 16'hD008;

  localparam int ERR_DATA  = 0;
  localparam int ERR_SEQ   = 1;
  localparam int ERR_SHORT = 2;
  localparam int ERR_LONG  = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/aurora_lfsr16.sv
// 16-bit payload LFSR with load and advance controls.
// A zero seed is replaced by 1 so the register never reaches the all-zero lock-up state.
module aurora_lfsr16
  import aurora_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        advance,
  output logic [15:0] value
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= 16'h0000;
    end else if (load) begin
      value <= (seed == 16'h0000) ? 16'h0001 : seed;
    end else if (advance) begin
      value <= lfsr_step(value);
    end
  end

endmodule

// File: rtl/aurora_frame_check.sv
// Aurora RX frame checker: verifies sequence continuity, the LFSR payload and the frame length.
// Also keeps the saturating error count, the sticky error flags and the frame counter.
module aurora_frame_check
  import aurora_pkg::*;
#(
  parameter int          N_LANE      = 1,
  parameter int          FRAME_WORDS = 16,
  parameter logic [15:0] LFSR_XOR    = 16'hA5A5
) (
  input  logic                  USER_CLK,
  input  logic                  RESET,
  input  logic                  CHANNEL_UP,
  input  logic [16*N_LANE-1:0]  RX_TDATA,
  input  logic                  RX_TVALID,
  input  logic                  RX_TLAST,
  output logic [7:0]            ERR_COUNT,
  output logic [3:0]            ERR_FLAGS,
  output logic [31:0]           FRAME_COUNT,
  output logic                  SYNCED
);

  localparam int DATA_W = 16 * N_LANE;
  localparam int BW     = $clog2(FRAME_WORDS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_WORDS - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t              state;
  state_t              next_state;
  logic [HDR_W-1:0]    exp_seq;
  logic [BW-1:0]       beat_cnt;
  logic [3:0]          err_frame;
  logic [15:0]         lfsr_val;

  logic                vld_p0;
  logic                hdr_acc_p0;
  logic                pay_acc_p0;
  logic [HDR_W-1:0]    hdr_seq_p0;
  logic [3:0]          beat_err_p0;
  logic [3:0]          frame_err_p0;
  logic                done_p0;
  logic [DATA_W-1:0]   exp_data_p0;

  // Stage p0: classify the incoming beat against the current state
  assign vld_p0       = RX_TVALID & CHANNEL_UP;
  assign hdr_acc_p0   = vld_p0 && (state == ST_HDR);
  assign pay_acc_p0   = vld_p0 && (state == ST_PAYLOAD);
  assign hdr_seq_p0   = RX_TDATA[HDR_W-1:0];
  assign exp_data_p0  = {N_LANE{lfsr_val}};
  assign frame_err_p0 = err_frame | beat_err_p0;

  aurora_lfsr16 u_lfsr (
    .clk     (USER_CLK),
    .rst     (RESET),
    .load    (hdr_acc_p0),
    .seed    (hdr_seq_p0 ^ LFSR_XOR),
    .advance (pay_acc_p0),
    .value   (lfsr_val)
  );

  always_comb begin
    next_state  = state;
    beat_err_p0 = 4'b0000;
    done_p0     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (CHANNEL_UP) next_state = ST_HDR;
      end
      ST_HDR: begin
        if (vld_p0) begin
          if (SYNCED && (hdr_seq_p0 != exp_seq)) beat_err_p0[ERR_SEQ] = 1'b1;
          if (RX_TLAST) begin
            beat_err_p0[ERR_SHORT] = 1'b1;
            done_p0                = 1'b1;
          end else begin
            next_state = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (vld_p0) begin
          if (RX_TDATA != exp_data_p0) beat_err_p0[ERR_DATA] = 1'b1;
          if (beat_cnt == LAST_BEAT) begin
            done_p0 = 1'b1;
            if (RX_TLAST) begin
              next_state = ST_HDR;
            end else begin
              beat_err_p0[ERR_LONG] = 1'b1;
              next_state            = ST_DRAIN;
            end
          end else if (RX_TLAST) begin
            beat_err_p0[ERR_SHORT] = 1'b1;
            done_p0                = 1'b1;
            next_state             = ST_HDR;
          end
        end
      end
      ST_DRAIN: begin
        if (vld_p0 && RX_TLAST) next_state = ST_HDR;
      end
      default: next_state = ST_IDLE;
    endcase
    // Losing the channel abandons any partial frame without counting it
    if (!CHANNEL_UP) begin
      next_state = ST_IDLE;
      done_p0    = 1'b0;
    end
  end

  // Stage p1: registered state, per-frame error accumulation and published counters
  always_ff @(posedge USER_CLK) begin
    if (RESET) begin
      state       <= ST_IDLE;
      exp_seq     <= '0;
      beat_cnt    <= '0;
      err_frame   <= 4'b0000;
      ERR_COUNT   <= 8'd0;
      ERR_FLAGS   <= 4'b0000;
      FRAME_COUNT <= 32'd0;
      SYNCED      <= 1'b0;
    end else begin
      state <= next_state;
      if (!CHANNEL_UP) begin
        SYNCED    <= 1'b0;
        err_frame <= 4'b0000;
      end else begin
        if (hdr_acc_p0) begin
          exp_seq  <= hdr_seq_p0 + 16'd1;
          SYNCED   <= 1'b1;
          beat_cnt <= BW'(1);
        end else if (pay_acc_p0) begin
          beat_cnt <= beat_cnt + 1'b1;
        end
        if (done_p0) begin
          FRAME_COUNT <= FRAME_COUNT + 32'd1;
          if (|frame_err_p0) begin
            ERR_COUNT <= sat_inc8(ERR_COUNT);
            ERR_FLAGS <= ERR_FLAGS | frame_err_p0;
          end
          err_frame <= 4'b0000;
        end else begin
          err_frame <= frame_err_p0;
        end
      end
    end
  end

endmodule

// File: tb/tb_aurora_frame_check.sv
// Randomised scoreboard bench for aurora_frame_check: a frame-level model predicts the counters
// after every completed frame, and a monitor compares them whenever FRAME_COUNT moves.
module tb_aurora_frame_check;

  localparam int          FW  = 16;
  localparam logic [15:0] XOR = 16'hA5A5;

  typedef struct {
    logic [31:0] fc;
    logic [7:0]  ec;
    logic [3:0]  ef;
    logic        sy;
  } exp_t;

  logic        USER_CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CHANNEL_UP = 1'b0;
  logic [15:0] RX_TDATA = 16'h0000;
  logic        RX_TVALID = 1'b0;
  logic        RX_TLAST = 1'b0;
  logic [7:0]  ERR_COUNT;
  logic [3:0]  ERR_FLAGS;
  logic [31:0] FRAME_COUNT;
  logic        SYNCED;

  aurora_frame_check #(.N_LANE(1), .FRAME_WORDS(FW), .LFSR_XOR(XOR)) dut (
    .USER_CLK    (USER_CLK),
    .RESET       (RESET),
    .CHANNEL_UP  (CHANNEL_UP),
    .RX_TDATA    (RX_TDATA),
    .RX_TVALID   (RX_TVALID),
    .RX_TLAST    (RX_TLAST),
    .ERR_COUNT   (ERR_COUNT),
    .ERR_FLAGS   (ERR_FLAGS),
    .FRAME_COUNT (FRAME_COUNT),
    .SYNCED      (SYNCED)
  );

  always #5 USER_CLK = ~USER_CLK;

  int          checks = 0;
  int          passes = 0;
  exp_t        exp_q[$];
  logic [31:0] last_fc = 32'd0;

  // Reference model state (frame-level view)
  logic [15:0] m_exp;
  logic        m_synced;
  logic [31:0] m_fc;
  logic [7:0]  m_ec;
  logic [3:0]  m_ef;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // Polynomial x^16+x^15+x^13+x^4+1: feedback is the XOR of the state bits at those exponents
  function automatic logic [15:0] ref_next(input logic [15:0] s);
    int   taps[4] = '{16, 15, 13, 4};
    logic fb;
    fb = 1'b0;
    foreach (taps[i]) fb ^= s[taps[i]-1];
    return {s[14:0], fb};
  endfunction

  function automatic logic [15:0] ref_seed(input logic [15:0] seq);
    logic [15:0] s;
    s = seq ^ XOR;
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  always @(negedge USER_CLK) begin
    if (RESET) begin
      last_fc = 32'd0;
    end else if (FRAME_COUNT !== last_fc) begin
      exp_t e;
      last_fc = FRAME_COUNT;
      if (exp_q.size() == 0) begin
        check("unexpected_frame", FRAME_COUNT, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("frame_count", FRAME_COUNT, e.fc);
        check("err_count", {24'd0, ERR_COUNT}, {24'd0, e.ec});
        check("err_flags", {28'd0, ERR_FLAGS}, {28'd0, e.ef});
        check("synced", {31'd0, SYNCED}, {31'd0, e.sy});
      end
    end
  end

  task automatic drive_beat(input logic [15:0] d, input logic last);
    while ($urandom_range(0, 3) == 0) begin
      RX_TVALID = 1'b0;
      RX_TDATA  = 16'($urandom);
      RX_TLAST  = 1'($urandom);
      @(posedge USER_CLK); #1;
    end
    RX_TVALID = 1'b1;
    RX_TDATA  = d;
    RX_TLAST  = last;
    @(posedge USER_CLK); #1;
    RX_TVALID = 1'b0;
    RX_TLAST  = 1'b0;
  endtask

  task automatic model_reset();
    m_exp = 16'd0; m_synced = 1'b0; m_fc = 32'd0; m_ec = 8'd0; m_ef = 4'd0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    RESET = 1'b1; CHANNEL_UP = 1'b0; RX_TVALID = 1'b0; RX_TLAST = 1'b0;
    repeat (2) @(posedge USER_CLK);
    #1;
    model_reset();
    RESET = 1'b0;
    CHANNEL_UP = 1'b1;
    @(posedge USER_CLK); #1;
  endtask

  // nbeats includes the header; corrupt_beat < 0 means a clean payload
  task automatic send_frame(input logic [15:0] seq, input int nbeats,
                            input int corrupt_beat, input logic [15:0] mask);
    logic [3:0]  errs;
    logic [15:0] pat;
    exp_t        e;
    int          checked;
    errs = 4'b0000;
    if (m_synced && seq != m_exp) errs[1] = 1'b1;
    m_exp    = seq + 16'd1;
    m_synced = 1'b1;
    if (nbeats < FW) errs[2] = 1'b1;
    if (nbeats > FW) errs[3] = 1'b1;
    checked = (nbeats < FW) ? nbeats : FW;
    if (corrupt_beat >= 1 && corrupt_beat < checked && mask != 16'd0) errs[0] = 1'b1;
    m_fc++;
    if (errs != 4'b0000) begin
      if (m_ec != 8'd255) m_ec++;
      m_ef |= errs;
    end
    e.fc = m_fc; e.ec = m_ec; e.ef = m_ef; e.sy = 1'b1;
    exp_q.push_back(e);

    drive_beat(seq, nbeats == 1);
    pat = ref_seed(seq);
    for (int k = 1; k < nbeats; k++) begin
      drive_beat((k == corrupt_beat) ? (pat ^ mask) : pat, k == nbeats - 1);
      pat = ref_next(pat);
    end
  endtask

  initial begin
    logic [15:0] pat;

    // Reset state
    repeat (3) @(posedge USER_CLK);
    #1;
    check("rst_err_count", {24'd0, ERR_COUNT}, 32'd0);
    check("rst_err_flags", {28'd0, ERR_FLAGS}, 32'd0);
    check("rst_frame_count", FRAME_COUNT, 32'd0);
    check("rst_synced", {31'd0, SYNCED}, 32'd0);

    // Clean frames with gaps
    do_reset();
    for (int s = 0; s < 3; s++) send_frame(16'(s), FW, -1, 16'd0);

    // Data error on payload beat 7 bit 3, then a clean frame
    do_reset();
    send_frame(16'd5, FW, 7, 16'h0008);
    send_frame(16'd6, FW, -1, 16'd0);

    // Sequence gaps, wrap and the zero-seed substitution
    do_reset();
    send_frame(16'd9, FW, -1, 16'd0);
    send_frame(16'd11, FW, -1, 16'd0);
    send_frame(16'd12, FW, -1, 16'd0);
    send_frame(16'hFFFF, FW, -1, 16'd0);
    send_frame(16'h0000, FW, -1, 16'd0);
    send_frame(16'hA5A5, FW, -1, 16'd0);
    send_frame(16'hA5A6, FW, -1, 16'd0);

    // Short frame, overlong frame, then a clean one; also a header-only frame
    do_reset();
    send_frame(16'd0, 10, -1, 16'd0);
    send_frame(16'd1, 21, -1, 16'd0);
    send_frame(16'd2, FW, 3, 16'h0000);
    send_frame(16'd3, 1, -1, 16'd0);
    send_frame(16'd4, FW, -1, 16'd0);

    // Channel loss mid-payload
    do_reset();
    send_frame(16'd7, FW, -1, 16'd0);
    drive_beat(16'd8, 1'b0);
    pat = ref_seed(16'd8);
    for (int k = 1; k < 5; k++) begin
      drive_beat(pat, 1'b0);
      pat = ref_next(pat);
    end
    CHANNEL_UP = 1'b0;
    @(posedge USER_CLK); #1;
    check("down_synced", {31'd0, SYNCED}, 32'd0);
    repeat (3) @(posedge USER_CLK);
    #1;
    check("down_frame_count", FRAME_COUNT, 32'd1);
    check("down_err_count", {24'd0, ERR_COUNT}, 32'd0);
    m_synced = 1'b0;
    CHANNEL_UP = 1'b1;
    @(posedge USER_CLK); #1;
    send_frame(16'd100, FW, -1, 16'd0);
    send_frame(16'd101, FW, -1, 16'd0);

    // Saturation over 300 corrupted frames, then reset mid-frame
    do_reset();
    for (int s = 0; s < 300; s++)
      send_frame(16'(s), FW, $urandom_range(1, FW - 1), 16'($urandom_range(1, 16'hFFFF)));
    repeat (2) @(posedge USER_CLK);
    #1;
    check("sat_err_count", {24'd0, ERR_COUNT}, 32'd255);
    check("sat_frame_count", FRAME_COUNT, 32'd300);
    check("sat_queue_empty", exp_q.size(), 32'd0);
    drive_beat(16'd300, 1'b0);
    drive_beat(ref_seed(16'd300), 1'b0);
    RESET = 1'b1;
    RX_TVALID = 1'b1;
    RX_TLAST = 1'b1;
    @(posedge USER_CLK); #1;
    check("mid_rst_err_count", {24'd0, ERR_COUNT}, 32'd0);
    check("mid_rst_err_flags", {28'd0, ERR_FLAGS}, 32'd0);
    check("mid_rst_frame_count", FRAME_COUNT, 32'd0);
    check("mid_rst_synced", {31'd0, SYNCED}, 32'd0);
    RX_TVALID = 1'b0;
    RX_TLAST = 1'b0;
    model_reset();
    RESET = 1'b0;
    CHANNEL_UP = 1'b1;
    @(posedge USER_CLK); #1;
    send_frame(16'd42, FW, -1, 16'd0);

    repeat (5) @(posedge USER_CLK);
    #1;
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/aurora_frame_check.md
Name: aurora_frame_check

Overview:
- Receive-side partner of the per-lane Aurora frame generator inside main; sits on the Aurora RX user interface (AXI4-Stream, streaming-framing mode) in the USER_CLK domain.
- Checks each incoming frame for:
  - sequence-number continuity;
  - the LFSR payload pattern;
  - exact frame length.
- Publishes a saturating error count, sticky error flags and a frame counter; main routes these to GPIO_LED for the two-board loopback bench.

Parameters:
N_LANE, 1, number of Aurora lanes; data width DW = 16*N_LANE
FRAME_WORDS, 16, beats per frame including header; legal range 2..1024
LFSR_XOR, 16'hA5A5, seed mask: payload LFSR seed = seq ^ LFSR_XOR

Ports:
USER_CLK  in  1  Aurora user clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
CHANNEL_UP  in  1  Aurora channel up
RX_TDATA  in  DW  received beat
RX_TVALID  in  1  beat valid; no ready (Aurora RX cannot be back-pressured)
RX_TLAST  in  1  last beat of frame
ERR_COUNT  out  8  frames with ≥1 error, saturates at 255
ERR_FLAGS  out  4  sticky: [0] data, [1] seq, [2] short, [3] long
FRAME_COUNT  out  32  frames completed (good or bad), wraps
SYNCED  out  1  expected sequence number established

Behaviour:
- Reset (RESET=1 on a clock edge):
  - all outputs 0; state IDLE; expected seq 0; LFSR 0.
  - RESET dominates every other input in the same cycle.
- Frame format:
  - beat 0 = header, seq in RX_TDATA[15:0], upper bits 0;
  - beats 1..FRAME_WORDS-1 carry the current 16-bit LFSR value replicated on every lane;
  - RX_TLAST is asserted only on beat FRAME_WORDS-1.
- LFSR: Fibonacci, x^16+x^15+x^13+x^4+1.
  - Loaded with seq^LFSR_XOR when the header is accepted.
  - Advances once after each payload beat is compared.
  - Value 0 is never produced: a seed of 0 is replaced by 16'h0001.
- State IDLE: wait for CHANNEL_UP=1 → HDR.
- State HDR (on RX_TVALID):
  - If SYNCED=1 and seq ≠ expected seq, set seq error.
  - Set expected seq = seq+1 mod 2^16 and SYNCED=1.
  - Load the LFSR and set beat counter = 1.
  - If RX_TLAST=1 on the header, flag a short error, complete the frame and stay in HDR.
  - Otherwise → PAYLOAD.
- State PAYLOAD (on RX_TVALID):
  - Compare RX_TDATA with the replicated LFSR; any mismatch sets a data error.
  - RX_TLAST=1 with beat counter < FRAME_WORDS-1: short error, complete frame → HDR.
  - Beat counter = FRAME_WORDS-1 with RX_TLAST=1: complete frame → HDR.
  - Beat counter = FRAME_WORDS-1 with RX_TLAST=0: long error, complete frame → DRAIN.
- State DRAIN: discard beats until a valid beat with RX_TLAST=1 → HDR. The overlong frame is counted once only.
- Frame completion:
  - FRAME_COUNT increments by 1.
  - If any error bit was set during the frame, ERR_COUNT increments by 1 (saturating) and the bits are ORed into ERR_FLAGS.
  - Per-frame error bits are then cleared.
- Latency: ERR_COUNT, ERR_FLAGS and FRAME_COUNT update on the clock edge after the completing beat (1 cycle, registered).
- RX_TVALID=0 cycles are ignored in every state; gaps inside a frame are legal.
- CHANNEL_UP falling in any state:
  - next state IDLE; SYNCED=0;
  - a partial frame is discarded without counting;
  - counters and flags are held.
- The first header after re-sync never raises a seq error.
- Sequence wrap: 16'hFFFF followed by 16'h0000 is legal.

Decomposition:
- Shared package aurora_pkg: LFSR polynomial tap mask, state encoding (IDLE/HDR/PAYLOAD/DRAIN), ERR_FLAGS bit indices, header field width (16).
- The same package is used by the existing frame generator, so both ends agree on the format.
- One natural sub-module, aurora_lfsr16: load/advance/value, shared with the generator.
- The checker FSM, counters and compare logic stay in aurora_frame_check.

Test Plan:
- Three clean frames, seq 0,1,2, FRAME_WORDS=16, with random TVALID gaps → FRAME_COUNT=3, ERR_COUNT=0, ERR_FLAGS=0, SYNCED=1.
- Frame seq 5 with payload beat 7 bit 3 flipped → ERR_COUNT=1, ERR_FLAGS=4'b0001; next clean frame seq 6 leaves ERR_COUNT=1.
- Seq 9 followed by seq 11 → ERR_FLAGS[1]=1, ERR_COUNT=1; then seq 12 gives no new error; seq 16'hFFFF then 16'h0000 gives no error.
- TLAST on beat 9, then frame with TLAST on beat 20 → ERR_FLAGS=4'b1100, ERR_COUNT=2, FRAME_COUNT=2; the following clean frame is checked normally.
- CHANNEL_UP dropped mid-payload, then up, then seq 100 → SYNCED=0 while down; no seq error on 100; partial frame not in FRAME_COUNT.
- 300 corrupted frames → ERR_COUNT=255 saturated, FRAME_COUNT=300; RESET asserted mid-frame → all outputs 0 on the next edge.
